// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
// Optional build macro: RST_SEQ_NEGEDGE_EN (all flops on negedge clk).
package rst_seq_pkg;

  typedef enum logic [2:0] {
    RESET,
    SYNC,
    HOLD,
    RELEASE,
    RUN
  } seq_state_e;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_MIN_HOLD    = 4;
  localparam int unsigned DEF_STAGGER     = 2;
  localparam int unsigned DEF_NUM_DOMAINS = 3;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Soft-request input and per-domain reset outputs of the reset sequencer.
// Optional build macro: RST_SEQ_NEGEDGE_EN (no effect on this file).
interface reset_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS
);
  logic                   soft_rst_req;
  logic [NUM_DOMAINS-1:0] rst_n;
  logic                   rst_done;
  logic                   busy;

  modport master (output soft_rst_req, input rst_n, input rst_done, input busy);
  modport slave  (input soft_rst_req, output rst_n, output rst_done, output busy);
endinterface

// File: rtl/reset_sequencer_sync_chain.sv
// Release synchroniser for the raw push-button reset, asynchronously cleared.
// Optional build macro: RST_SEQ_NEGEDGE_EN (flops clocked on negedge clk).
module sync_chain
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic RST_n,
  output logic sync_o
);
  // The sequencer's SYNC->HOLD state flop is the final stage, so HOLD
  // begins on the very edge the synchronised release lands.
  localparam int unsigned DEPTH = SYNC_STAGES - 1;

  logic [DEPTH-1:0] sync_q;

`ifdef RST_SEQ_NEGEDGE_EN
  always_ff @(negedge clk or negedge RST_n) begin
`else
  always_ff @(posedge clk or negedge RST_n) begin
`endif
    if (!RST_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= 1'b1;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_o = sync_q[DEPTH-1];
endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: synchronised release, minimum hold, staggered domain release.
// Optional build macro: RST_SEQ_NEGEDGE_EN (all flops clocked on negedge clk).
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned MIN_HOLD    = DEF_MIN_HOLD,
  parameter int unsigned STAGGER     = DEF_STAGGER,
  parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS
) (
  input  logic             clk,
  input  logic             RST_n,
  reset_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(max(MIN_HOLD, STAGGER) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

  seq_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_DOMAINS-1:0] rst_n_q;
  logic [NUM_DOMAINS-1:0] rst_n_d;
  logic                   done_q;
  logic                   busy_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_last;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .RST_n (RST_n),
    .sync_o(synced)
  );

  // Next release step shifts one more 1 in from bit 0.
  assign rst_n_d  = (rst_n_q << 1) | NUM_DOMAINS'(1);
  assign cnt_last = (state_q == HOLD) ? HOLD_LAST : STAG_LAST;

`ifdef RST_SEQ_NEGEDGE_EN
  always_ff @(negedge clk or negedge RST_n) begin
`else
  always_ff @(posedge clk or negedge RST_n) begin
`endif
    if (!RST_n) begin
      state_q <= RESET;
      cnt_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        RESET: state_q <= SYNC;
        SYNC: begin
          if (synced) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        HOLD, RELEASE, RUN: begin
          if (bus.soft_rst_req) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (state_q != RUN) begin
            // HOLD and RELEASE share the release step; only the period differs.
            if (cnt_q == cnt_last) begin
              cnt_q   <= '0;
              rst_n_q <= rst_n_d;
              if (&rst_n_d) begin
                state_q <= RUN;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= RELEASE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= RESET;
      endcase
    end
  end

  assign bus.rst_n    = rst_n_q;
  assign bus.rst_done = done_q;
  assign bus.busy     = busy_q;
endmodule
